cpu_ctrl: RTL and testbench
===========================

CPU_CTRL -- requirements
Module: cpu_ctrl

Interface
REQ-001 SHALL have parameter PC_W, default 16, meaning program-counter width.
REQ-002 SHALL have parameter RESET_PC, default 0, meaning PC value loaded on reset.
REQ-003 SHALL have the following ports; clock is clk and reset is rst, with one clock and reset asynchronous and active-high:
- clk  in  1  clock
- rst  in  1  asynchronous active-high reset
- instr  in  32  fetched word: op[31:26], rd[25:21], rs[20:16], imm[15:0]
- pc  out  PC_W  instruction address
- ir_load  out  1  capture instr into IR
- alu_eq, alu_lt  in  1 each  rd==rs and rd<rs (signed), valid in EXEC
- alu_op  out  4  ALU function
- alu_src_imm  out  1  ALU operand B = extended imm
- imm_mode  out  2  0 sign-extend, 1 zero-extend, 2 imm<<16
- reg_we  out  1  register-file write strobe, WB only
- mem_req  out  1  data-memory request
- mem_we  out  1  store qualifier of mem_req
- mem_ready  in  1  memory completion
- illegal  out  1  sticky illegal-opcode flag

Function
REQ-010 SHALL be a multi-cycle FSM: FETCH, DECODE, EXEC, MEM, WB, HALT.
REQ-011 FETCH SHALL assert ir_load for one cycle; next state DECODE.
REQ-012 DECODE: NOOP (000000) SHALL set pc=pc+1 and return to FETCH (2 cycles total); all other opcodes go to EXEC.
REQ-013 R-type (MOV 010000, ADD 010010, SUB 010011, OR 010100, AND 010101, XOR 010110, SLT 010111) SHALL take EXEC->WB, alu_src_imm=0; 4 cycles total.
REQ-014 I-type (ADDI 110010, SUBI 110011, SLTI 110111 sign-extend; ORI 110100, ANDI 110101, XORI 110110 zero-extend; LI 111001 sign-extend; LUI 111010 mode 2) SHALL take EXEC->WB, alu_src_imm=1; 4 cycles total.
REQ-015 BEQ 100000, BNE 100001, BLT 100010, BLE 100011 SHALL sample alu_eq/alu_lt in EXEC; taken: pc=pc+1+sext(imm); not taken: pc=pc+1; then FETCH (3 cycles total).
REQ-016 J (000001) SHALL set pc=imm zero-extended to PC_W in EXEC, then FETCH.
REQ-017 LW 111101, SW 111110 (address rs+sext(imm)) and LWI 111011, SWI 111100 (address zext(imm)) SHALL go EXEC->MEM; mem_req held high in MEM until mem_ready is sampled high.
REQ-018 Loads SHALL go MEM->WB; stores SHALL go MEM->FETCH with pc=pc+1 and reg_we never asserted.
REQ-019 mem_ready high in the first MEM cycle SHALL give a 1-cycle MEM; mem_ready asserted outside MEM SHALL be ignored.
REQ-020 WB SHALL assert reg_we for exactly one cycle and set pc=pc+1.
REQ-021 PC arithmetic SHALL wrap modulo 2^PC_W: pc=all-ones +1 -> 0; branch offsets wrap without saturation.
REQ-022 Outputs other than pc SHALL be Moore-decoded from state and IR; there is at most one pc update per instruction.

Reset
REQ-030 rst SHALL asynchronously force state=FETCH, pc=RESET_PC, IR=0, illegal=0, and all strobes (ir_load excepted) low.
REQ-031 rst asserted mid-instruction, including in MEM with mem_req high, SHALL drop mem_req immediately; the aborted access is not retried.
REQ-032 The first FETCH SHALL occur on the first clk rising edge after rst deasserts.

Configuration
REQ-040 With CPU_CTRL_ILLEGAL_TRAP_EN defined, an undefined opcode in DECODE SHALL set illegal=1 and enter HALT; HALT is left only by rst.
REQ-041 Without CPU_CTRL_ILLEGAL_TRAP_EN defined, undefined opcodes SHALL execute as NOOP and illegal SHALL be tied to 0.

Structure
REQ-050 Opcode constants, alu_op encodings, imm_mode encodings and the state enum SHALL reside in shared package cpu_pkg.
REQ-051 Opcode-to-control decoding SHALL be a combinational sub-module ctrl_decode; cpu_ctrl holds state, PC and IR.

Verification
REQ-060 rst released, instr=ADDI r1,r1,5 -> ir_load at cycle 0, reg_we at cycle 3, pc 0->1, imm_mode=0.
REQ-061 pc=15, BEQ imm=1 with alu_eq=1 -> pc=17 after 3 cycles; with alu_eq=0 -> pc=16.
REQ-062 SWI imm=8 with mem_ready delayed 3 cycles -> mem_req high for 4 cycles, mem_we=1, no reg_we, pc+1.
REQ-063 pc=26, J imm=0 -> pc=0; pc=FFFF, NOOP -> pc=0.
REQ-064 rst pulsed during a LW MEM wait -> mem_req low asynchronously, pc=RESET_PC, state FETCH.
REQ-065 Opcode 111111 -> with macro: illegal=1, pc frozen; without macro: pc+1 after 2 cycles.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared opcode, ALU, immediate-mode and FSM definitions for the multi-cycle CPU controller.
package cpu_pkg;

    localparam logic [5:0] OP_NOOP = 6'b000000;
    localparam logic [5:0] OP_J    = 6'b000001;
    localparam logic [5:0] OP_MOV  = 6'b010000;
    localparam logic [5:0] OP_ADD  = 6'b010010;
    localparam logic [5:0] OP_SUB  = 6'b010011;
    localparam logic [5:0] OP_OR   = 6'b010100;
    localparam logic [5:0] OP_AND  = 6'b010101;
    localparam logic [5:0] OP_XOR  = 6'b010110;
    localparam logic [5:0] OP_SLT  = 6'b010111;
    localparam logic [5:0] OP_BEQ  = 6'b100000;
    localparam logic [5:0] OP_BNE  = 6'b100001;
    localparam logic [5:0] OP_BLT  = 6'b100010;
    localparam logic [5:0] OP_BLE  = 6'b100011;
    localparam logic [5:0] OP_ADDI = 6'b110010;
    localparam logic [5:0] OP_SUBI = 6'b110011;
    localparam logic [5:0] OP_ORI  = 6'b110100;
    localparam logic [5:0] OP_ANDI = 6'b110101;
    localparam logic [5:0] OP_XORI = 6'b110110;
    localparam logic [5:0] OP_SLTI = 6'b110111;
    localparam logic [5:0] OP_LI   = 6'b111001;
    localparam logic [5:0] OP_LUI  = 6'b111010;
    localparam logic [5:0] OP_LWI  = 6'b111011;
    localparam logic [5:0] OP_SWI  = 6'b111100;
    localparam logic [5:0] OP_LW   = 6'b111101;
    localparam logic [5:0] OP_SW   = 6'b111110;

    typedef enum logic [3:0] {
        ALU_NOP, ALU_MOV, ALU_ADD, ALU_SUB, ALU_OR, ALU_AND, ALU_XOR, ALU_SLT, ALU_PASSB
    } alu_op_e;

    typedef enum logic [1:0] {
        IMM_SEXT = 2'd0,
        IMM_ZEXT = 2'd1,
        IMM_HI   = 2'd2
    } imm_mode_e;

    typedef enum logic [2:0] {
        S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_HALT
    } state_e;

    typedef enum logic [2:0] {
        K_NOOP, K_ALU, K_BRANCH, K_JUMP, K_LOAD, K_STORE, K_ILLEGAL
    } kind_e;

    typedef enum logic [1:0] {BR_EQ, BR_NE, BR_LT, BR_LE} br_cond_e;

    typedef struct packed {
        kind_e     kind;
        alu_op_e   alu_op;
        logic      src_imm;
        imm_mode_e imm_mode;
        br_cond_e  br;
    } ctrl_t;

    function automatic logic br_taken(input br_cond_e c, input logic eq, input logic lt);
        case (c)
            BR_EQ:   return eq;
            BR_NE:   return !eq;
            BR_LT:   return lt;
            default: return lt | eq;
        endcase
    endfunction

endpackage

// File: rtl/cpu_ctrl_decode.sv
// Combinational opcode decoder: instruction class plus the static ALU/immediate controls.
module ctrl_decode
    import cpu_pkg::*;
(
    input  logic [5:0] op,
    output ctrl_t      ctrl
);

    always_comb begin
        ctrl = '{K_ILLEGAL, ALU_NOP, 1'b0, IMM_SEXT, BR_EQ};
        case (op)
            OP_NOOP: ctrl.kind = K_NOOP;
            OP_J:    begin ctrl.kind = K_JUMP; ctrl.imm_mode = IMM_ZEXT; end
            OP_MOV:  begin ctrl.kind = K_ALU; ctrl.alu_op = ALU_MOV; end
            OP_ADD:  begin ctrl.kind = K_ALU; ctrl.alu_op = ALU_ADD; end
            OP_SUB:  begin ctrl.kind = K_ALU; ctrl.alu_op = ALU_SUB; end
            OP_OR:   begin ctrl.kind = K_ALU; ctrl.alu_op = ALU_OR;  end
            OP_AND:  begin ctrl.kind = K_ALU; ctrl.alu_op = ALU_AND; end
            OP_XOR:  begin ctrl.kind = K_ALU; ctrl.alu_op = ALU_XOR; end
            OP_SLT:  begin ctrl.kind = K_ALU; ctrl.alu_op = ALU_SLT; end
            // branches compare rd against rs, so operand B stays the register
            OP_BEQ:  begin ctrl.kind = K_BRANCH; ctrl.alu_op = ALU_SUB; ctrl.br = BR_EQ; end
            OP_BNE:  begin ctrl.kind = K_BRANCH; ctrl.alu_op = ALU_SUB; ctrl.br = BR_NE; end
            OP_BLT:  begin ctrl.kind = K_BRANCH; ctrl.alu_op = ALU_SUB; ctrl.br = BR_LT; end
            OP_BLE:  begin ctrl.kind = K_BRANCH; ctrl.alu_op = ALU_SUB; ctrl.br = BR_LE; end
            OP_ADDI: begin ctrl.kind = K_ALU; ctrl.alu_op = ALU_ADD; ctrl.src_imm = 1'b1; end
            OP_SUBI: begin ctrl.kind = K_ALU; ctrl.alu_op = ALU_SUB; ctrl.src_imm = 1'b1; end
            OP_SLTI: begin ctrl.kind = K_ALU; ctrl.alu_op = ALU_SLT; ctrl.src_imm = 1'b1; end
            OP_ORI:  begin ctrl.kind = K_ALU; ctrl.alu_op = ALU_OR;  ctrl.src_imm = 1'b1; ctrl.imm_mode = IMM_ZEXT; end
            OP_ANDI: begin ctrl.kind = K_ALU; ctrl.alu_op = ALU_AND; ctrl.src_imm = 1'b1; ctrl.imm_mode = IMM_ZEXT; end
            OP_XORI: begin ctrl.kind = K_ALU; ctrl.alu_op = ALU_XOR; ctrl.src_imm = 1'b1; ctrl.imm_mode = IMM_ZEXT; end
            OP_LI:   begin ctrl.kind = K_ALU; ctrl.alu_op = ALU_PASSB; ctrl.src_imm = 1'b1; end
            OP_LUI:  begin ctrl.kind = K_ALU; ctrl.alu_op = ALU_PASSB; ctrl.src_imm = 1'b1; ctrl.imm_mode = IMM_HI; end
            OP_LW:   begin ctrl.kind = K_LOAD;  ctrl.alu_op = ALU_ADD; ctrl.src_imm = 1'b1; end
            OP_SW:   begin ctrl.kind = K_STORE; ctrl.alu_op = ALU_ADD; ctrl.src_imm = 1'b1; end
            OP_LWI:  begin ctrl.kind = K_LOAD;  ctrl.alu_op = ALU_PASSB; ctrl.src_imm = 1'b1; ctrl.imm_mode = IMM_ZEXT; end
            OP_SWI:  begin ctrl.kind = K_STORE; ctrl.alu_op = ALU_PASSB; ctrl.src_imm = 1'b1; ctrl.imm_mode = IMM_ZEXT; end
            default: ;
        endcase
    end

endmodule

// File: rtl/cpu_ctrl.sv
// Multi-cycle CPU controller: state, PC and IR; controls are Moore-decoded from state and IR.
// Define CPU_CTRL_ILLEGAL_TRAP_EN to trap undefined opcodes into HALT with a sticky illegal flag.
module cpu_ctrl
    import cpu_pkg::*;
#(
    parameter int              PC_W     = 16,
    parameter logic [PC_W-1:0] RESET_PC = '0
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [31:0]     instr,
    output logic [PC_W-1:0] pc,
    output logic            ir_load,
    input  logic            alu_eq,
    input  logic            alu_lt,
    output logic [3:0]      alu_op,
    output logic            alu_src_imm,
    output logic [1:0]      imm_mode,
    output logic            reg_we,
    output logic            mem_req,
    output logic            mem_we,
    input  logic            mem_ready,
    output logic            illegal
);

    localparam logic [PC_W-1:0] PC_ONE = PC_W'(1);

    state_e          state, state_nx;
    logic [31:0]     ir;
    logic [PC_W-1:0] pc_nx, pc_inc, pc_off, pc_jmp;
    logic [9:0]      unused_regs;
    ctrl_t           ctrl;

    ctrl_decode u_dec (
        .op   (ir[31:26]),
        .ctrl (ctrl)
    );

    // register fields feed the datapath, not the sequencer
    assign unused_regs = ir[25:16];

    assign pc_inc = pc + PC_ONE;
    assign pc_off = PC_W'($signed(ir[15:0]));
    assign pc_jmp = PC_W'(ir[15:0]);

`ifdef CPU_CTRL_ILLEGAL_TRAP_EN
    logic ill_set;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_FETCH;
            pc    <= RESET_PC;
            ir    <= '0;
        end else begin
            state <= state_nx;
            pc    <= pc_nx;
            if (state == S_FETCH) ir <= instr;
        end
    end

`ifdef CPU_CTRL_ILLEGAL_TRAP_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst)          illegal <= 1'b0;
        else if (ill_set) illegal <= 1'b1;
    end
`else
    assign illegal = 1'b0;
`endif

    always_comb begin
        state_nx    = state;
        pc_nx       = pc;
`ifdef CPU_CTRL_ILLEGAL_TRAP_EN
        ill_set     = 1'b0;
`endif
        ir_load     = (state == S_FETCH);
        reg_we      = (state == S_WB);
        mem_req     = (state == S_MEM);
        mem_we      = (state == S_MEM) && (ctrl.kind == K_STORE);
        alu_op      = ctrl.alu_op;
        alu_src_imm = ctrl.src_imm;
        imm_mode    = ctrl.imm_mode;

        case (state)
            S_FETCH: state_nx = S_DECODE;
            S_DECODE: begin
                case (ctrl.kind)
                    K_NOOP: begin
                        pc_nx    = pc_inc;
                        state_nx = S_FETCH;
                    end
                    K_ILLEGAL: begin
`ifdef CPU_CTRL_ILLEGAL_TRAP_EN
                        ill_set  = 1'b1;
                        state_nx = S_HALT;
`else
                        pc_nx    = pc_inc;
                        state_nx = S_FETCH;
`endif
                    end
                    default: state_nx = S_EXEC;
                endcase
            end
            S_EXEC: begin
                case (ctrl.kind)
                    K_BRANCH: begin
                        pc_nx    = br_taken(ctrl.br, alu_eq, alu_lt) ? pc_inc + pc_off : pc_inc;
                        state_nx = S_FETCH;
                    end
                    K_JUMP: begin
                        pc_nx    = pc_jmp;
                        state_nx = S_FETCH;
                    end
                    K_LOAD, K_STORE: state_nx = S_MEM;
                    default:         state_nx = S_WB;
                endcase
            end
            S_MEM: begin
                if (mem_ready) begin
                    if (ctrl.kind == K_STORE) begin
                        pc_nx    = pc_inc;
                        state_nx = S_FETCH;
                    end else begin
                        state_nx = S_WB;
                    end
                end
            end
            S_WB: begin
                pc_nx    = pc_inc;
                state_nx = S_FETCH;
            end
            S_HALT:  state_nx = S_HALT;
            default: state_nx = S_FETCH;
        endcase
    end

endmodule

// File: tb/tb_cpu_ctrl.sv
// Randomized bench for cpu_ctrl against an instruction-level schedule model.
module tb_cpu_ctrl;

    localparam int          PC_W   = 16;
    localparam logic [15:0] RST_PC = 16'h0000;
`ifdef CPU_CTRL_ILLEGAL_TRAP_EN
    localparam bit TRAP = 1'b1;
`else
    localparam bit TRAP = 1'b0;
`endif

    logic            clk = 1'b0, rst = 1'b1;
    logic [31:0]     instr = '0;
    logic            alu_eq = 1'b0, alu_lt = 1'b0, mem_ready = 1'b0;
    logic [PC_W-1:0] pc;
    logic            ir_load, alu_src_imm, reg_we, mem_req, mem_we, illegal;
    logic [3:0]      alu_op;
    logic [1:0]      imm_mode;

    int vectors = 0, miscompares = 0;

    logic        chk_en = 1'b0;
    logic        e_ir, e_we, e_mreq, e_mwe, e_ill, e_chkimm, e_src;
    logic [1:0]  e_mode;
    logic [15:0] e_pc;
    logic [15:0] mpc;
    logic        halted;

    cpu_ctrl #(.PC_W(PC_W), .RESET_PC(RST_PC)) dut (
        .clk(clk), .rst(rst), .instr(instr), .pc(pc), .ir_load(ir_load),
        .alu_eq(alu_eq), .alu_lt(alu_lt), .alu_op(alu_op), .alu_src_imm(alu_src_imm),
        .imm_mode(imm_mode), .reg_we(reg_we), .mem_req(mem_req), .mem_we(mem_we),
        .mem_ready(mem_ready), .illegal(illegal)
    );

    always #5 clk = ~clk;

    // single per-cycle compare against the model's expectations
    always @(negedge clk) begin
        if (chk_en) begin
            vectors++;
            if (ir_load !== e_ir || reg_we !== e_we || mem_req !== e_mreq || mem_we !== e_mwe ||
                pc !== e_pc || illegal !== e_ill ||
                (e_chkimm && (alu_src_imm !== e_src || imm_mode !== e_mode))) begin
                miscompares++;
                $display("FAIL cycle t=%0t got/exp ir_load=%b/%b reg_we=%b/%b mem_req=%b/%b mem_we=%b/%b pc=%h/%h illegal=%b/%b src=%b/%b mode=%0d/%0d",
                         $time, ir_load, e_ir, reg_we, e_we, mem_req, e_mreq, mem_we, e_mwe,
                         pc, e_pc, illegal, e_ill, alu_src_imm, e_src, imm_mode, e_mode);
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s got=%h exp=%h", name, act, exp);
        end
    endtask

    // 0 noop, 1 alu, 2 branch, 3 jump, 4 load, 5 store, 6 undefined
    function automatic int classify(input logic [5:0] op, output logic src, output logic [1:0] mode);
        src = 1'b0; mode = 2'd0;
        case (op)
            6'b000000: return 0;
            6'b000001: return 3;
            6'b010000, 6'b010010, 6'b010011, 6'b010100,
            6'b010101, 6'b010110, 6'b010111: return 1;
            6'b110010, 6'b110011, 6'b110111, 6'b111001: begin src = 1'b1; return 1; end
            6'b110100, 6'b110101, 6'b110110: begin src = 1'b1; mode = 2'd1; return 1; end
            6'b111010: begin src = 1'b1; mode = 2'd2; return 1; end
            6'b100000, 6'b100001, 6'b100010, 6'b100011: return 2;
            6'b111101: begin src = 1'b1; return 4; end
            6'b111011: begin src = 1'b1; mode = 2'd1; return 4; end
            6'b111110: begin src = 1'b1; return 5; end
            6'b111100: begin src = 1'b1; mode = 2'd1; return 5; end
            default: return 6;
        endcase
    endfunction

    task automatic do_reset();
        chk_en = 1'b0;
        rst = 1'b1;
        @(posedge clk); #1;
        check("rst_pc", 32'(pc), 32'(RST_PC));
        check("rst_mem_req", 32'(mem_req), 32'd0);
        check("rst_reg_we", 32'(reg_we), 32'd0);
        check("rst_illegal", 32'(illegal), 32'd0);
        check("rst_ir_load", 32'(ir_load), 32'd1);
        rst = 1'b0;
        mpc = RST_PC;
    endtask

    // entered at posedge+1 with the DUT in FETCH; d = extra MEM wait cycles
    task automatic run_instr(input logic [31:0] ins, input logic eq, input logic lt,
                             input int d, output logic halt_o);
        logic src, taken, mem_in;
        logic [1:0] mode;
        logic [5:0] op;
        logic [15:0] imm;
        int kind, n;
        op = ins[31:26];
        imm = ins[15:0];
        kind = classify(op, src, mode);
        if (kind == 6 && !TRAP) kind = 0;
        case (kind)
            1: n = 4;
            2, 3: n = 3;
            4: n = 5 + d;
            5: n = 4 + d;
            default: n = 2;
        endcase
        for (int k = 0; k < n; k++) begin
            instr     = (k == 0) ? ins : $urandom;
            alu_eq    = (k == 2) ? eq : 1'($urandom);
            alu_lt    = (k == 2) ? lt : 1'($urandom);
            mem_in    = (kind == 4 || kind == 5) && k >= 3 && k <= 3 + d;
            mem_ready = mem_in ? (k == 3 + d) : 1'($urandom);
            e_ir = (k == 0); e_we = (kind == 1 || kind == 4) && k == n - 1;
            e_mreq = mem_in; e_mwe = mem_in && kind == 5; e_ill = 1'b0; e_pc = mpc;
            e_chkimm = (kind == 1 || kind == 4 || kind == 5) && k >= 1;
            e_src = src; e_mode = mode; chk_en = 1'b1;
            @(posedge clk); #1;
        end
        halt_o = 1'b0;
        taken = (op == 6'b100000 && eq) || (op == 6'b100001 && !eq) ||
                (op == 6'b100010 && lt) || (op == 6'b100011 && (lt || eq));
        case (kind)
            2: mpc = taken ? mpc + 16'd1 + imm : mpc + 16'd1;
            3: mpc = imm;
            6: begin
                for (int k = 0; k < 4; k++) begin
                    instr = $urandom; mem_ready = 1'($urandom);
                    e_ir = 1'b0; e_we = 1'b0; e_mreq = 1'b0; e_mwe = 1'b0;
                    e_ill = 1'b1; e_pc = mpc; e_chkimm = 1'b0; chk_en = 1'b1;
                    @(posedge clk); #1;
                end
                halt_o = 1'b1;
            end
            default: mpc = mpc + 16'd1;
        endcase
        chk_en = 1'b0;
    endtask

    logic [5:0] ops [25] = '{6'b000000, 6'b000001, 6'b010000, 6'b010010, 6'b010011, 6'b010100,
                             6'b010101, 6'b010110, 6'b010111, 6'b100000, 6'b100001, 6'b100010,
                             6'b100011, 6'b110010, 6'b110011, 6'b110100, 6'b110101, 6'b110110,
                             6'b110111, 6'b111001, 6'b111010, 6'b111011, 6'b111100, 6'b111101,
                             6'b111110};

    initial begin
        logic [31:0] w;
        mpc = RST_PC;
        repeat (2) @(posedge clk);
        #1;
        do_reset();

        run_instr({6'b110010, 5'd1, 5'd1, 16'd5}, 1'b0, 1'b0, 0, halted);
        check("addi_pc", 32'(pc), 32'h1);

        run_instr({6'b000001, 10'd0, 16'd15}, 1'b0, 1'b0, 0, halted);
        check("j15_pc", 32'(pc), 32'd15);
        run_instr({6'b100000, 5'd2, 5'd3, 16'd1}, 1'b1, 1'b0, 0, halted);
        check("beq_taken_pc", 32'(pc), 32'd17);
        run_instr({6'b000001, 10'd0, 16'd15}, 1'b0, 1'b0, 0, halted);
        run_instr({6'b100000, 5'd2, 5'd3, 16'd1}, 1'b0, 1'b1, 0, halted);
        check("beq_not_taken_pc", 32'(pc), 32'd16);

        run_instr({6'b111100, 10'd0, 16'd8}, 1'b0, 1'b0, 3, halted);
        check("swi_pc", 32'(pc), 32'd17);

        run_instr({6'b000001, 10'd0, 16'd26}, 1'b0, 1'b0, 0, halted);
        run_instr({6'b000001, 10'd0, 16'd0}, 1'b0, 1'b0, 0, halted);
        check("j0_pc", 32'(pc), 32'd0);
        run_instr({6'b000001, 10'd0, 16'hFFFF}, 1'b0, 1'b0, 0, halted);
        run_instr({6'b000000, 26'h155_5555}, 1'b0, 1'b0, 0, halted);
        check("noop_wrap_pc", 32'(pc), 32'd0);

        // reset while a load waits in MEM
        run_instr({6'b000001, 10'd0, 16'd5}, 1'b0, 1'b0, 0, halted);
        instr = {6'b111101, 5'd1, 5'd2, 16'h0010};
        mem_ready = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        check("lw_wait_mem_req", 32'(mem_req), 32'd1);
        #2 rst = 1'b1;
        #1;
        check("lw_abort_mem_req", 32'(mem_req), 32'd0);
        check("lw_abort_pc", 32'(pc), 32'(RST_PC));
        check("lw_abort_fetch", 32'(ir_load), 32'd1);
        @(posedge clk); #1;
        rst = 1'b0;
        mpc = RST_PC;

        run_instr({6'b000001, 10'd0, 16'd100}, 1'b0, 1'b0, 0, halted);
        run_instr({6'b111111, 26'h3AB_CDEF}, 1'b0, 1'b0, 0, halted);
        if (TRAP) begin
            check("trap_pc_frozen", 32'(pc), 32'd100);
            check("trap_illegal", 32'(illegal), 32'd1);
            do_reset();
        end else begin
            check("undef_noop_pc", 32'(pc), 32'd101);
        end

        for (int i = 0; i < 400; i++) begin
            w = $urandom;
            if ($urandom_range(0, 9) < 8) w[31:26] = ops[$urandom_range(0, 24)];
            run_instr(w, 1'($urandom), 1'($urandom), $urandom_range(0, 4), halted);
            if (halted) do_reset();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
